xgs_tpg_multilane: RTL and testbench
====================================

// Module: xgs_tpg_multilane
// PURPOSE
//  Parametrised multi-lane test-pattern generator for the XGS athena datapath; replaces per-test hard-coded stimulus.
//  Emits one frame of NUM_LANES pixels per beat on an AXI-stream-like port, framed by SOF/EOL flags.
//  Pattern, geometry and blanking are runtime-configurable.
//  Sits between the register file and the HiSPi/line-buffer input mux, selected in validation modes.
// PARAMETERS
//  NUM_LANES   6   pixels per beat (lanes)
//  PIX_WIDTH   12  bits per pixel
//  XCNT_WIDTH  13  width of beats-per-line counter
//  YCNT_WIDTH  12  width of line counter
// PORTS
//  sclk          in   1                     system clock
//  srst          in   1                     asynchronous reset, active-high
//  cfg_start     in   1                     one-cycle pulse: sample cfg_*, start one frame
//  cfg_abort     in   1                     level: terminate frame at next beat boundary
//  cfg_mode      in   2                     0 ramp, 1 constant, 2 checkerboard, 3 LFSR
//  cfg_line_beats in  XCNT_WIDTH            beats per line
//  cfg_lines     in   YCNT_WIDTH            lines per frame
//  cfg_hblank    in   8                     idle cycles between lines
//  cfg_seed      in   PIX_WIDTH             ramp offset / constant value / LFSR seed (low bits)
//  tready        in   1                     downstream ready
//  tvalid        out  1                     beat valid
//  tdata         out  NUM_LANES*PIX_WIDTH   lane 0 in LSBs
//  tuser_sof     out  1                     first beat of frame
//  tlast_eol     out  1                     last beat of line
//  busy          out  1                     frame in progress
//  done          out  1                     one-cycle pulse at frame end (normal or aborted)
//  frame_cnt     out  16                    completed (non-aborted) frames, wraps at 0xFFFF->0
//  frame_checksum out 32                    see CONFIGURATION
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, LFSR = 16'hACE1.
//  FSM IDLE -> LINE on cfg_start with nonzero geometry; LINE -> HBLANK after accepted EOL beat if lines remain
//   and cfg_hblank!=0; LINE -> LINE (next line) if cfg_hblank==0; last EOL accepted -> DONE; DONE -> IDLE (1 cycle, done=1).
//  cfg_* registered at start; changes during a frame are ignored. cfg_start while busy is ignored.
//  cfg_line_beats==0 or cfg_lines==0: no beats, done pulses 1 cycle after start, frame_cnt unchanged.
//  Latency: tvalid rises the cycle after cfg_start. Beat accepted when tvalid&&tready; while tvalid&&!tready,
//   tdata/tuser_sof/tlast_eol/tvalid are held stable. HBLANK holds tvalid=0 for exactly cfg_hblank cycles.
//  Pixel (x=beat index in line, y=line, l=lane), truncated to PIX_WIDTH:
//   ramp: x*NUM_LANES+l+cfg_seed; constant: cfg_seed; checker: ((x^y)&1)? all-ones : 0;
//   LFSR: lane l = LFSR[PIX_WIDTH-1:0] rotated left by l; LFSR advances once per accepted beat.
//  Abort: if tvalid&&!tready, the pending beat completes first; then -> DONE, done pulses, frame_cnt not incremented.
//  Abort asserted in IDLE has no effect; abort and start in the same IDLE cycle: start ignored.
//  Async reset mid-frame: immediate return to reset values, no done pulse.
// CONFIGURATION
//  Macro XGS_TPG_CHECKSUM_EN:
//   defined: frame_checksum = modulo-2^32 sum of all pixels of all accepted beats; cleared at start,
//    valid and stable from the done pulse until next start.
//   undefined: frame_checksum tied to 32'h0, no accumulator logic.
// STRUCTURE
//  Package xgs_tpg_pkg: tpg_mode_e (RAMP, CONST, CHECKER, LFSR), tpg_state_e (IDLE, LINE, HBLANK, DONE),
//   LFSR_RESET = 16'hACE1, LFSR_TAPS polynomial x^16+x^14+x^13+x^11+1.
//  Sub-module xgs_tpg_lfsr: 16-bit Fibonacci LFSR, ports sclk, srst, load, seed, advance, state.
//  Top: FSM, x/y counters, blank counter, pixel mux, output register stage, checksum accumulator.
// TESTING
//  T1 ramp, NUM_LANES=6, seed=0, beats=4, lines=2, hblank=3, tready=1 -> 8 beats; beat0 lanes 0..5,
//   beat3 lanes 18..23 with EOL; 3 idle cycles between lines; SOF only on beat0; done once; frame_cnt=1.
//  T2 constant seed=0xABC, beats=2, lines=1, tready toggling 1010... -> tdata held while stalled, 2 beats all 0xABC.
//  T3 start with cfg_lines=0 -> no tvalid, done 1 cycle after start, frame_cnt unchanged; start while busy ignored.
//  T4 abort raised mid-line with tready=0 -> pending beat held until tready, then done, frame_cnt unchanged.
//  T5 checker beats=2, lines=2, hblank=0 -> lines back-to-back, beat(0,0)=0x000, (1,0)=0xFFF, (0,1)=0xFFF.
//  T6 with XGS_TPG_CHECKSUM_EN: T1 frame -> frame_checksum = 0+1+..+23 = 276 per line, 552 total; without macro -> 0.

Source files
------------

// File: rtl/xgs_tpg_pkg.sv
// Shared types and constants for the XGS multi-lane test-pattern generator.
package xgs_tpg_pkg;

  // Pattern selector, encoded as the cfg_mode register field.
  typedef enum logic [1:0] {
    RAMP    = 2'd0,
    CONST   = 2'd1,
    CHECKER = 2'd2,
    LFSR    = 2'd3
  } tpg_mode_e;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LINE   = 2'd1,
    HBLANK = 2'd2,
    DONE   = 2'd3
  } tpg_state_e;

  localparam logic [15:0] LFSR_RESET = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10.
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  // One Fibonacci step: XOR of tapped bits shifts in at the LSB.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/xgs_tpg_lfsr.sv
// 16-bit Fibonacci LFSR with synchronous load and advance strobes.
module xgs_tpg_lfsr
  import xgs_tpg_pkg::*;
(
  input  logic        sclk,
  input  logic        srst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] state
);

  // Load has priority so a frame start always begins from the seed.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst)         state <= LFSR_RESET;
    else if (load)    state <= seed;
    else if (advance) state <= lfsr_next(state);
  end

endmodule

// File: rtl/xgs_tpg_multilane.sv
// Multi-lane test-pattern generator: one frame of NUM_LANES pixels per beat,
// framed by SOF/EOL, with runtime pattern, geometry and horizontal blanking.
// Optional feature macro: XGS_TPG_CHECKSUM_EN (per-frame pixel sum).
//
// Handshake: a beat is transferred on a cycle where tvalid && tready. Once
// tvalid is high, tvalid/tdata/tuser_sof/tlast_eol stay unchanged until that
// transfer happens; tvalid never depends combinationally on tready.
module xgs_tpg_multilane
  import xgs_tpg_pkg::*;
#(
  parameter int NUM_LANES  = 6,
  parameter int PIX_WIDTH  = 12,
  parameter int XCNT_WIDTH = 13,
  parameter int YCNT_WIDTH = 12
) (
  input  logic                           sclk,
  input  logic                           srst,
  input  logic                           cfg_start,
  input  logic                           cfg_abort,
  input  logic [1:0]                     cfg_mode,
  input  logic [XCNT_WIDTH-1:0]          cfg_line_beats,
  input  logic [YCNT_WIDTH-1:0]          cfg_lines,
  input  logic [7:0]                     cfg_hblank,
  input  logic [PIX_WIDTH-1:0]           cfg_seed,
  input  logic                           tready,
  output logic                           tvalid,
  output logic [NUM_LANES*PIX_WIDTH-1:0] tdata,
  output logic                           tuser_sof,
  output logic                           tlast_eol,
  output logic                           busy,
  output logic                           done,
  output logic [15:0]                    frame_cnt,
  output logic [31:0]                    frame_checksum,
  output tpg_state_e                     dbg_state
);

  tpg_state_e              state_q, state_d;
  tpg_mode_e               mode_q;
  logic [XCNT_WIDTH-1:0]   beats_q, x_q;
  logic [YCNT_WIDTH-1:0]   lines_q, y_q;
  logic [7:0]              hblank_q, blank_q;
  logic [PIX_WIDTH-1:0]    seed_q;
  logic [15:0]             frame_cnt_q;
  logic [15:0]             lfsr_state, seed_ext;
  logic [PIX_WIDTH-1:0]    pix [NUM_LANES];
  logic                    accept, last_x, last_y;
  logic                    cfg_load, beat_inc, line_adv, blank_load, cnt_inc;
  logic                    unused_lfsr_hi;

  assign accept = (state_q == LINE) && tready;
  assign last_x = (x_q == beats_q - XCNT_WIDTH'(1));
  assign last_y = (y_q == lines_q - YCNT_WIDTH'(1));

  // Sequencer state register.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and datapath strobes; a completed last beat counts as a
  // normal frame even if abort is raised on that same beat.
  always_comb begin
    state_d    = state_q;
    cfg_load   = 1'b0;
    beat_inc   = 1'b0;
    line_adv   = 1'b0;
    blank_load = 1'b0;
    cnt_inc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start && !cfg_abort) begin
          cfg_load = 1'b1;
          state_d  = (cfg_line_beats == '0 || cfg_lines == '0) ? DONE : LINE;
        end
      end
      LINE: begin
        if (accept) begin
          if (last_x && last_y) begin
            state_d = DONE;
            cnt_inc = 1'b1;
          end else if (cfg_abort) begin
            state_d = DONE;
          end else if (last_x) begin
            line_adv = 1'b1;
            if (hblank_q != 8'd0) begin
              state_d    = HBLANK;
              blank_load = 1'b1;
            end
          end else begin
            beat_inc = 1'b1;
          end
        end
      end
      HBLANK: begin
        if (cfg_abort)             state_d = DONE;
        else if (blank_q == 8'd1)  state_d = LINE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Configuration capture, beat/line/blank counters and completed-frame count.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      mode_q      <= RAMP;
      beats_q     <= '0;
      lines_q     <= '0;
      hblank_q    <= '0;
      seed_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      blank_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (cfg_load) begin
        mode_q   <= tpg_mode_e'(cfg_mode);
        beats_q  <= cfg_line_beats;
        lines_q  <= cfg_lines;
        hblank_q <= cfg_hblank;
        seed_q   <= cfg_seed;
        x_q      <= '0;
        y_q      <= '0;
      end else if (line_adv) begin
        x_q <= '0;
        y_q <= y_q + YCNT_WIDTH'(1);
      end else if (beat_inc) begin
        x_q <= x_q + XCNT_WIDTH'(1);
      end
      if (blank_load)              blank_q <= hblank_q;
      else if (state_q == HBLANK)  blank_q <= blank_q - 8'd1;
      if (cnt_inc) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  // Seed occupies the LFSR low bits; an all-zero state would lock up.
  always_comb begin
    seed_ext = LFSR_RESET;
    seed_ext[PIX_WIDTH-1:0] = cfg_seed;
    if (seed_ext == 16'h0) seed_ext = LFSR_RESET;
  end

  xgs_tpg_lfsr u_lfsr (
    .sclk    (sclk),
    .srst    (srst),
    .load    (cfg_load),
    .seed    (seed_ext),
    .advance (accept),
    .state   (lfsr_state)
  );

  assign unused_lfsr_hi = ^lfsr_state[15:PIX_WIDTH];

  // Pixel mux: every source is a register, so the beat holds while stalled.
  always_comb begin
    logic [PIX_WIDTH-1:0] ramp_base, lfsr_low;
    ramp_base = PIX_WIDTH'(32'(x_q) * NUM_LANES) + seed_q;
    lfsr_low  = lfsr_state[PIX_WIDTH-1:0];
    for (int l = 0; l < NUM_LANES; l++) begin
      case (mode_q)
        RAMP:    pix[l] = ramp_base + PIX_WIDTH'(l);
        CONST:   pix[l] = seed_q;
        CHECKER: pix[l] = {PIX_WIDTH{x_q[0] ^ y_q[0]}};
        LFSR:    pix[l] = (lfsr_low << (l % PIX_WIDTH)) |
                          (lfsr_low >> (PIX_WIDTH - (l % PIX_WIDTH)));
        default: pix[l] = '0;
      endcase
    end
  end

  // Output decode; data forced to zero outside LINE so idle outputs read 0.
  always_comb begin
    tdata = '0;
    for (int l = 0; l < NUM_LANES; l++)
      tdata[l*PIX_WIDTH +: PIX_WIDTH] = (state_q == LINE) ? pix[l] : '0;
  end

  assign tvalid    = (state_q == LINE);
  assign tuser_sof = tvalid && (x_q == '0) && (y_q == '0);
  assign tlast_eol = tvalid && last_x;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign frame_cnt = frame_cnt_q;
  assign dbg_state = state_q;

`ifdef XGS_TPG_CHECKSUM_EN
  logic [31:0] beat_sum, checksum_q;

  // Sum of the lanes of the beat currently presented.
  always_comb begin
    beat_sum = '0;
    for (int l = 0; l < NUM_LANES; l++) beat_sum = beat_sum + 32'(pix[l]);
  end

  // Frame checksum: cleared on start, accumulates accepted beats only.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst)          checksum_q <= '0;
    else if (cfg_load) checksum_q <= '0;
    else if (accept)   checksum_q <= checksum_q + beat_sum;
  end

  assign frame_checksum = checksum_q;
`else
  assign frame_checksum = 32'h0;
`endif

endmodule

// File: tb/tb_xgs_tpg_multilane.sv
// Self-checking bench for xgs_tpg_multilane: table-driven frames, hand-written
// abort/start/reset sequences and random frames against a behavioural model.
module tb_xgs_tpg_multilane;
  import xgs_tpg_pkg::*;

  localparam int NL = 6, PW = 12, XW = 13, YW = 12;
  localparam int DW = NL * PW;
  localparam int W  = DW + 2;   // {sof, eol, tdata}

  logic          sclk = 1'b0, srst = 1'b1;
  logic          cfg_start = 1'b0, cfg_abort = 1'b0;
  logic [1:0]    cfg_mode = '0;
  logic [XW-1:0] cfg_line_beats = '0;
  logic [YW-1:0] cfg_lines = '0;
  logic [7:0]    cfg_hblank = '0;
  logic [PW-1:0] cfg_seed = '0;
  logic          tready = 1'b0;
  logic          tvalid, tuser_sof, tlast_eol, busy, done;
  logic [DW-1:0] tdata;
  logic [15:0]   frame_cnt;
  logic [31:0]   frame_checksum;
  tpg_state_e    dbg_state;

  int            n_checks = 0, n_fail = 0, exp_frames = 0;
  logic [W-1:0]  exp_q[$];

  typedef struct {
    int mode; int beats; int lines; int hblank; int seed;
    int rmode;        // 0 always ready, 1 toggling 1010..., 2 random
    bit busy_start;   // pulse a conflicting start mid-frame
    int exp_beats;
    int exp_cs;       // known checksum, or -1 when only the model applies
  } vec_t;

  xgs_tpg_multilane dut (
    .sclk(sclk), .srst(srst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_mode(cfg_mode), .cfg_line_beats(cfg_line_beats), .cfg_lines(cfg_lines),
    .cfg_hblank(cfg_hblank), .cfg_seed(cfg_seed), .tready(tready),
    .tvalid(tvalid), .tdata(tdata), .tuser_sof(tuser_sof), .tlast_eol(tlast_eol),
    .busy(busy), .done(done), .frame_cnt(frame_cnt),
    .frame_checksum(frame_checksum), .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  always #5 sclk = ~sclk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model -------------------------------------------------------
  function automatic logic [15:0] model_lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  function automatic logic [PW-1:0] model_pix(input int mode, input int x, input int y,
                                              input int l, input int seed, input logic [15:0] s);
    logic [PW-1:0] v;
    case (mode)
      0: v = PW'(x * NL + l + seed);
      1: v = PW'(seed);
      2: v = (((x ^ y) & 1) != 0) ? {PW{1'b1}} : '0;
      default: begin
        v = s[PW-1:0];
        for (int r = 0; r < l; r++) v = {v[PW-2:0], v[PW-1]};
      end
    endcase
    return v;
  endfunction

  task automatic build_expected(input vec_t v, output logic [31:0] sum);
    logic [15:0]   s;
    logic [DW-1:0] d;
    logic [PW-1:0] p;
    exp_q.delete();
    sum = 0;
    s = 16'hACE1;
    s[PW-1:0] = v.seed[PW-1:0];
    for (int y = 0; y < v.lines; y++)
      for (int x = 0; x < v.beats; x++) begin
        for (int l = 0; l < NL; l++) begin
          p = model_pix(v.mode, x, y, l, v.seed, s);
          d[l*PW +: PW] = p;
          sum += 32'(p);
        end
        exp_q.push_back({(x == 0 && y == 0), (x == v.beats - 1), d});
        s = model_lfsr_step(s);
      end
`ifndef XGS_TPG_CHECKSUM_EN
    sum = 0;
`endif
  endtask

  // Driver tasks (all start and end 1 time unit after a rising edge) -------
  task automatic pulse_start(input vec_t v);
    cfg_mode       = 2'(v.mode);
    cfg_line_beats = XW'(v.beats);
    cfg_lines      = YW'(v.lines);
    cfg_hblank     = 8'(v.hblank);
    cfg_seed       = PW'(v.seed);
    cfg_start      = 1'b1;
    @(posedge sclk); #1;
    cfg_start      = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    int cyc = 0, nbeats = 0, gap = 0;
    bit seen_done = 0, want_gap = 0, prev_stall = 0, zero;
    logic [W-1:0]  prev = '0, got;
    logic [31:0]   exp_sum;
    build_expected(v, exp_sum);
    zero = (v.beats == 0 || v.lines == 0);
    pulse_start(v);
    while (!seen_done && cyc < 2000) begin
      case (v.rmode)
        0:       tready = 1'b1;
        1:       tready = (cyc % 2 == 0);
        default: tready = 1'($urandom_range(0, 1));
      endcase
      if (v.busy_start && cyc == 2) begin
        cfg_start = 1'b1;
        cfg_mode = ~cfg_mode; cfg_seed = ~cfg_seed;
        cfg_line_beats = cfg_line_beats + 1'b1; cfg_lines = 7;
      end else cfg_start = 1'b0;
      @(negedge sclk);
      if (cyc == 0) check("start_latency_tvalid", tvalid, !zero);
      if (prev_stall) check("stall_hold", {tvalid, tuser_sof, tlast_eol, tdata}, {1'b1, prev});
      if (tvalid && want_gap) begin
        check("hblank_gap", gap, v.hblank);
        want_gap = 0;
      end else if (!tvalid && want_gap) gap++;
      if (tvalid && tready) begin
        got = {tuser_sof, tlast_eol, tdata};
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL extra_beat: got 0x%0h expected no beat", got);
        end else check("beat", got, exp_q.pop_front());
        nbeats++;
        want_gap = tlast_eol && (nbeats != v.beats * v.lines);
        gap = 0;
      end
      if (done) seen_done = 1;
      prev_stall = tvalid && !tready;
      prev = {tuser_sof, tlast_eol, tdata};
      @(posedge sclk); #1;
      cyc++;
    end
    cfg_start = 1'b0;
    check("done_seen", seen_done, 1'b1);
    @(negedge sclk);
    check("done_one_cycle", {done, busy}, 2'b00);
    check("beat_count", nbeats, v.exp_beats);
    if (!zero) exp_frames++;
    check("frame_cnt", frame_cnt, exp_frames);
    check("checksum_model", frame_checksum, exp_sum);
`ifdef XGS_TPG_CHECKSUM_EN
    if (v.exp_cs >= 0) check("checksum_ref", frame_checksum, v.exp_cs);
`else
    if (v.exp_cs >= 0) check("checksum_tied_zero", frame_checksum, 0);
`endif
    @(posedge sclk); #1;
  endtask

  // Main sequence -----------------------------------------------------------
  initial begin
    vec_t          tbl[8];
    vec_t          v;
    logic [31:0]   dummy;
    logic [W-1:0]  held;

    //          mode bt ln hb seed   rm bs exp cs
    tbl[0] = '{0,  4, 2, 3, 0,     0, 0, 8,  552};  // ramp frame
    tbl[1] = '{1,  2, 1, 0, 'hABC, 1, 0, 2,  -1};   // constant, stalls
    tbl[2] = '{0,  3, 0, 2, 5,     0, 0, 0,  -1};   // zero lines
    tbl[3] = '{1,  0, 2, 1, 7,     0, 0, 0,  -1};   // zero beats
    tbl[4] = '{2,  2, 2, 0, 0,     0, 0, 4,  -1};   // checker, no blanking
    tbl[5] = '{3,  3, 2, 1, 'h5A3, 2, 1, 6,  -1};   // LFSR, start while busy
    tbl[6] = '{0,  5, 3, 2, 'hFFE, 1, 1, 15, -1};   // ramp wrap, start while busy
    tbl[7] = '{2,  1, 3, 0, 0,     0, 0, 3,  -1};   // single-beat lines

    // Reset.
    repeat (3) @(posedge sclk);
    #1 srst = 1'b0;
    @(negedge sclk);
    check("reset_outputs", {tvalid, tuser_sof, tlast_eol, busy, done}, 5'b0);
    check("reset_tdata", tdata, 0);
    check("reset_frame_cnt", frame_cnt, 0);
    check("reset_checksum", frame_checksum, 0);
    check("reset_state", dbg_state, IDLE);
    @(posedge sclk); #1;

    foreach (tbl[i]) run_frame(tbl[i]);

    // Abort while a beat is stalled: the beat completes, then done, no count.
    v = '{0, 4, 2, 3, 0, 0, 0, 0, -1};
    build_expected(v, dummy);
    pulse_start(v);
    tready = 1'b1;
    repeat (2) begin @(negedge sclk); void'(exp_q.pop_front()); @(posedge sclk); #1; end
    tready = 1'b0; cfg_abort = 1'b1;
    held = exp_q.pop_front();
    repeat (3) begin
      @(negedge sclk);
      check("abort_hold", {tvalid, tuser_sof, tlast_eol, tdata}, {1'b1, held});
      @(posedge sclk); #1;
    end
    tready = 1'b1;
    @(negedge sclk);
    check("abort_last_beat", {tvalid, tuser_sof, tlast_eol, tdata}, {1'b1, held});
    @(posedge sclk); #1;
    @(negedge sclk);
    check("abort_done", {done, tvalid}, 2'b10);
    check("abort_frame_cnt", frame_cnt, exp_frames);
    @(posedge sclk); #1;
    @(negedge sclk);
    check("abort_idle", {done, busy}, 2'b00);
    @(posedge sclk); #1;

    // Abort and start together in IDLE: start ignored.
    pulse_start('{0, 4, 2, 0, 0, 0, 0, 0, -1});
    @(negedge sclk);
    check("abort_start_ignored", {busy, tvalid, done}, 3'b000);
    @(posedge sclk); #1;
    cfg_abort = 1'b0;

    // Random frames.
    for (int k = 0; k < 8; k++) begin
      v.mode = $urandom_range(0, 3);  v.beats = $urandom_range(1, 5);
      v.lines = $urandom_range(1, 3); v.hblank = $urandom_range(0, 3);
      v.seed = $urandom_range(0, 4095); v.rmode = 2; v.busy_start = 0;
      v.exp_beats = v.beats * v.lines; v.exp_cs = -1;
      run_frame(v);
    end

    // Asynchronous reset mid-frame: immediate return to reset values, no done.
    pulse_start('{0, 4, 3, 1, 0, 0, 0, 0, -1});
    tready = 1'b1;
    repeat (3) @(posedge sclk);
    #2 srst = 1'b1;
    #1;
    check("async_reset_outputs", {tvalid, busy, done, tuser_sof, tlast_eol}, 5'b0);
    check("async_reset_frame_cnt", frame_cnt, 0);
    @(negedge sclk);
    check("async_reset_no_done", {done, tdata}, 0);
    @(posedge sclk); #1 srst = 1'b0;
    exp_frames = 0;
    run_frame(tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
